// File: rtl/reg_writeback_arbiter_pkg.sv
// Shared widths and the buffered write-back entry layout used by the
// register write-back arbiter and its result FIFO.
package reg_writeback_arbiter_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/reg_writeback_arbiter_if.sv
// Pipeline WB, long-latency result handshake and register-file write port
// bundled as one interface; the arbiter is the slave side.
interface reg_writeback_arbiter_if;
    import reg_writeback_arbiter_pkg::*;

    logic              wb_valid_i;
    logic [REG_AW-1:0] wb_addr_i;
    logic [REG_DW-1:0] wb_data_i;
    logic              lu_valid_i;
    logic [REG_AW-1:0] lu_addr_i;
    logic [REG_DW-1:0] lu_data_i;
    logic              lu_ready_o;
    logic              RegWrite_o;
    logic [REG_AW-1:0] RDaddr_o;
    logic [REG_DW-1:0] RDdata_o;

    modport slave (
        input  wb_valid_i, wb_addr_i, wb_data_i,
        input  lu_valid_i, lu_addr_i, lu_data_i,
        output lu_ready_o,
        output RegWrite_o, RDaddr_o, RDdata_o
    );

    modport master (
        output wb_valid_i, wb_addr_i, wb_data_i,
        output lu_valid_i, lu_addr_i, lu_data_i,
        input  lu_ready_o,
        input  RegWrite_o, RDaddr_o, RDdata_o
    );

endinterface

// File: rtl/reg_writeback_arbiter_wb_fifo.sv
// Small FIFO holding long-latency write-back results until the write port is free.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module wb_fifo
    import reg_writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      push_i,
    input  wb_entry_t push_entry_i,
    input  logic      pop_i,
    output wb_entry_t head_o,
    output logic      full_o,
    output logic      empty_o,
    output logic      full_next_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    wb_entry_t   mem_q [DEPTH];

    assign wr_ptr_d = wr_ptr_q + (AW+1)'(push_i);
    assign rd_ptr_d = rd_ptr_q + (AW+1)'(pop_i);

    assign empty_o     = (wr_ptr_q == rd_ptr_q);
    assign full_o      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                         (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign full_next_o = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                         (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    assign head_o      = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_entry_i;
        end
    end

endmodule

// File: rtl/reg_writeback_arbiter.sv
// Register-file write-port arbiter: pipeline WB has priority, long-latency results
// drain from a FIFO in the gaps; tracks pending destinations and starvation.
module reg_writeback_arbiter
    import reg_writeback_arbiter_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    reg_writeback_arbiter_if.slave      bus,
    input  logic                        pend_set_i,
    input  logic [REG_AW-1:0]           pend_addr_i,
    input  logic [REG_AW-1:0]           RSaddr_i,
    input  logic [REG_AW-1:0]           RTaddr_i,
    output logic                        RSbusy_o,
    output logic                        RTbusy_o,
    output logic                        stall_o
);

    localparam int CW = $clog2(STARVE_LIMIT) + 1;
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT - 1);

    logic      push, pop, full, empty, full_next;
    wb_entry_t head, push_entry;

    logic [31:0]   pend_q, pend_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          stall_q, stall_d;

    logic              reg_write;
    logic [REG_AW-1:0] rd_addr;
    logic [REG_DW-1:0] rd_data;

    assign push_entry = '{addr: bus.lu_addr_i, data: bus.lu_data_i};
    assign push       = bus.lu_valid_i & !full;
    assign pop        = !rst_i & !bus.wb_valid_i & !empty;

    assign bus.lu_ready_o = !full;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_entry_i(push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (full),
        .empty_o     (empty),
        .full_next_o (full_next)
    );

    // Writes to r0 are suppressed, but a FIFO head addressed to r0 still drains.
    always_comb begin
        reg_write = 1'b0;
        rd_addr   = REG_ZERO;
        rd_data   = '0;
        if (bus.wb_valid_i) begin
            reg_write = (bus.wb_addr_i != REG_ZERO);
            rd_addr   = bus.wb_addr_i;
            rd_data   = bus.wb_data_i;
        end else if (!empty) begin
            reg_write = (head.addr != REG_ZERO);
            rd_addr   = head.addr;
            rd_data   = head.data;
        end
        if (rst_i) begin
            reg_write = 1'b0;
        end
    end

    assign bus.RegWrite_o = reg_write;
    assign bus.RDaddr_o   = rd_addr;
    assign bus.RDdata_o   = rd_data;

    // A new dispatch to the register being retired this cycle must stay pending.
    always_comb begin
        pend_d = pend_q;
        if (pop) begin
            pend_d[head.addr] = 1'b0;
        end
        if (pend_set_i && (pend_addr_i != REG_ZERO)) begin
            pend_d[pend_addr_i] = 1'b1;
        end
    end

    assign RSbusy_o = pend_q[RSaddr_i] & !(pop && (head.addr == RSaddr_i));
    assign RTbusy_o = pend_q[RTaddr_i] & !(pop && (head.addr == RTaddr_i));

    always_comb begin
        if (empty || pop) begin
            starve_d = '0;
        end else if (starve_q == STARVE_MAX) begin
            starve_d = starve_q;
        end else begin
            starve_d = starve_q + 1'b1;
        end
        stall_d = (starve_d >= STARVE_MAX) | full_next;
    end

    assign stall_o = stall_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q   <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Directed bench for reg_writeback_arbiter: expected register-file writes go into a
// queue as stimulus is issued and a negedge monitor matches them against the port.
module tb_reg_writeback_arbiter;
    import reg_writeback_arbiter_pkg::*;

    logic        clk_i;
    logic        rst_i;
    logic        pend_set_i;
    logic [4:0]  pend_addr_i;
    logic [4:0]  RSaddr_i;
    logic [4:0]  RTaddr_i;
    logic        RSbusy_o;
    logic        RTbusy_o;
    logic        stall_o;

    int checks = 0;
    int fails  = 0;
    wb_entry_t expectQ[$];

    reg_writeback_arbiter_if bus();

    reg_writeback_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .bus        (bus),
        .pend_set_i (pend_set_i),
        .pend_addr_i(pend_addr_i),
        .RSaddr_i   (RSaddr_i),
        .RTaddr_i   (RTaddr_i),
        .RSbusy_o   (RSbusy_o),
        .RTbusy_o   (RTbusy_o),
        .stall_o    (stall_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic wbv, input logic [4:0] wba, input logic [31:0] wbd,
                                 input logic luv, input logic [4:0] lua, input logic [31:0] lud,
                                 input logic ps, input logic [4:0] pa);
        bus.wb_valid_i = wbv;
        bus.wb_addr_i  = wba;
        bus.wb_data_i  = wbd;
        bus.lu_valid_i = luv;
        bus.lu_addr_i  = lua;
        bus.lu_data_i  = lud;
        pend_set_i     = ps;
        pend_addr_i    = pa;
    endtask

    task automatic expectWrite(input logic [4:0] a, input logic [31:0] d);
        expectQ.push_back('{addr: a, data: d});
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Every register-file write must match the oldest outstanding expectation.
    always @(negedge clk_i) begin
        if (!rst_i && bus.RegWrite_o) begin
            checks++;
            if (expectQ.size() == 0) begin
                fails++;
                $display("[TB] FAIL unexpected write: got addr %0d data %0h, expected no write",
                         bus.RDaddr_o, bus.RDdata_o);
            end else begin
                wb_entry_t exp;
                exp = expectQ.pop_front();
                if (bus.RDaddr_o !== exp.addr || bus.RDdata_o !== exp.data) begin
                    fails++;
                    $display("[TB] FAIL write port: got addr %0d data %0h, expected addr %0d data %0h",
                             bus.RDaddr_o, bus.RDdata_o, exp.addr, exp.data);
                end
            end
        end
    end

    initial begin
        rst_i    = 1'b1;
        RSaddr_i = 5'd9;
        RTaddr_i = 5'd12;
        applyStimulus(1'b1, 5'd5, 32'h1111, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);

        $display("[TB] reset with wb_valid held");
        @(negedge clk_i);
        checkOutput("reset RegWrite", 32'(bus.RegWrite_o), 0);
        checkOutput("reset lu_ready", 32'(bus.lu_ready_o), 1);
        checkOutput("reset RSbusy", 32'(RSbusy_o), 0);
        checkOutput("reset RTbusy", 32'(RTbusy_o), 0);
        checkOutput("reset stall", 32'(stall_o), 0);

        $display("[TB] pipeline write");
        step();
        rst_i = 1'b0;
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        expectWrite(5'd5, 32'hDEADBEEF);
        @(negedge clk_i);
        checkOutput("wb RegWrite", 32'(bus.RegWrite_o), 1);

        $display("[TB] pending set then long-latency result");
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
        @(negedge clk_i);
        checkOutput("RSbusy before set", 32'(RSbusy_o), 0);
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        @(negedge clk_i);
        checkOutput("RSbusy pending", 32'(RSbusy_o), 1);
        step();
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h1234, 1'b0, 5'd0);
        @(negedge clk_i);
        checkOutput("RSbusy at push", 32'(RSbusy_o), 1);
        checkOutput("no bypass on push", 32'(bus.RegWrite_o), 0);
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        expectWrite(5'd9, 32'h1234);
        @(negedge clk_i);
        checkOutput("RSbusy during pop", 32'(RSbusy_o), 0);
        step();
        @(negedge clk_i);
        checkOutput("RSbusy after pop", 32'(RSbusy_o), 0);

        $display("[TB] fill FIFO behind pipeline writes");
        for (int i = 0; i < 4; i++) begin
            step();
            applyStimulus(1'b1, 5'(i + 1), 32'h100 + 32'(i), 1'b1, 5'(16 + i), 32'hA0 + 32'(i),
                          1'b0, 5'd0);
            expectWrite(5'(i + 1), 32'h100 + 32'(i));
            @(negedge clk_i);
            checkOutput("fill lu_ready", 32'(bus.lu_ready_o), 1);
            checkOutput("fill stall", 32'(stall_o), 0);
        end
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 32'hFFFF, 1'b0, 5'd0);
        expectWrite(5'd16, 32'hA0);
        @(negedge clk_i);
        checkOutput("full lu_ready", 32'(bus.lu_ready_o), 0);
        checkOutput("full stall", 32'(stall_o), 1);
        for (int i = 1; i < 4; i++) begin
            step();
            applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
            expectWrite(5'(16 + i), 32'hA0 + 32'(i));
            @(negedge clk_i);
            checkOutput("drain lu_ready", 32'(bus.lu_ready_o), 1);
            checkOutput("drain stall", 32'(stall_o), 0);
        end
        step();
        @(negedge clk_i);
        checkOutput("drained RegWrite", 32'(bus.RegWrite_o), 0);

        $display("[TB] starvation behind continuous pipeline writes");
        step();
        applyStimulus(1'b1, 5'd2, 32'h200, 1'b1, 5'd21, 32'h5555, 1'b0, 5'd0);
        expectWrite(5'd2, 32'h200);
        @(negedge clk_i);
        checkOutput("starve stall p0", 32'(stall_o), 0);
        for (int i = 1; i < 8; i++) begin
            step();
            applyStimulus(1'b1, 5'd2, 32'h200 + 32'(i), 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
            expectWrite(5'd2, 32'h200 + 32'(i));
            @(negedge clk_i);
            checkOutput("starve stall low", 32'(stall_o), 0);
        end
        step();
        applyStimulus(1'b1, 5'd2, 32'h208, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        expectWrite(5'd2, 32'h208);
        @(negedge clk_i);
        checkOutput("starve stall high", 32'(stall_o), 1);
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        expectWrite(5'd21, 32'h5555);
        @(negedge clk_i);
        checkOutput("bubble stall held", 32'(stall_o), 1);
        step();
        @(negedge clk_i);
        checkOutput("stall after bubble", 32'(stall_o), 0);

        $display("[TB] r0 entry and set-wins-over-clear");
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12);
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hBAD, 1'b0, 5'd0);
        @(negedge clk_i);
        checkOutput("RTbusy pending 12", 32'(RTbusy_o), 1);
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hC0FFEE, 1'b0, 5'd0);
        @(negedge clk_i);
        checkOutput("r0 pop RegWrite", 32'(bus.RegWrite_o), 0);
        checkOutput("RTbusy behind r0", 32'(RTbusy_o), 1);
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12);
        expectWrite(5'd12, 32'hC0FFEE);
        @(negedge clk_i);
        checkOutput("RTbusy during pop", 32'(RTbusy_o), 0);
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        @(negedge clk_i);
        checkOutput("set wins RTbusy", 32'(RTbusy_o), 1);
        checkOutput("empty after r0", 32'(bus.RegWrite_o), 0);
        checkOutput("empty lu_ready", 32'(bus.lu_ready_o), 1);

        $display("[TB] reset mid-operation");
        RSaddr_i = 5'd7;
        step();
        applyStimulus(1'b1, 5'd3, 32'h333, 1'b1, 5'd7, 32'h777, 1'b1, 5'd7);
        expectWrite(5'd3, 32'h333);
        @(negedge clk_i);
        checkOutput("RSbusy 7 before set", 32'(RSbusy_o), 0);
        step();
        applyStimulus(1'b1, 5'd3, 32'h334, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        rst_i = 1'b1;
        @(negedge clk_i);
        checkOutput("midreset RegWrite", 32'(bus.RegWrite_o), 0);
        checkOutput("midreset RSbusy", 32'(RSbusy_o), 0);
        checkOutput("midreset RTbusy", 32'(RTbusy_o), 0);
        checkOutput("midreset lu_ready", 32'(bus.lu_ready_o), 1);
        step();
        rst_i = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        @(negedge clk_i);
        checkOutput("post reset RegWrite", 32'(bus.RegWrite_o), 0);

        step();
        @(negedge clk_i);
        checkOutput("expected writes outstanding", 32'(expectQ.size()), 0);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
